// File: rtl/mmio_io_ctrl.sv
// rtl/mmio_io_ctrl.sv - memory-mapped LED/hex-display/switch peripheral for the upper address half
module mmio_io_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 9,
    parameter int DIGITS   = 4,
    parameter int SW_W     = 10,
    parameter int LED_W    = 9,
    parameter int DEBOUNCE = 16,
    parameter int BLINK_W  = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mem_cmd,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  io_sel,
    input  logic [SW_W-1:0]       sw,
    output logic [LED_W-1:0]      led,
    output logic [7*DIGITS-1:0]   segs
);

    localparam int OFF_W = ADDR_W - 1;
    localparam int HEX_W = 4 * DIGITS;
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [OFF_W-1:0] OFF_SWITCH = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_LED    = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_HEXVAL = OFF_W'(2);
    localparam logic [OFF_W-1:0] OFF_CTRL   = OFF_W'(3);
    localparam logic [OFF_W-1:0] OFF_STATUS = OFF_W'(4);
    localparam logic [CNT_W-1:0] DB_MAX     = CNT_W'(DEBOUNCE - 1);

    logic               io_space;
    logic               wr_en;
    logic               rd_en;
    logic [OFF_W-1:0]   offset;

    logic [LED_W-1:0]   led_reg;
    logic [HEX_W-1:0]   hex_reg;
    logic [2:0]         ctrl_reg;
    logic [SW_W-1:0]    sw_sync1;
    logic [SW_W-1:0]    sw_sync2;
    logic [SW_W-1:0]    sw_cand;
    logic [SW_W-1:0]    sw_stable;
    logic [CNT_W-1:0]   db_cnt;
    logic               changed;
    logic [BLINK_W-1:0] blink_cnt;

    logic               sw_diff;
    logic               sw_accept;
    logic               changed_set;
    logic               status_clr;

    assign io_space = mem_addr[ADDR_W-1];
    assign offset   = mem_addr[OFF_W-1:0];
    assign wr_en    = io_space && (mem_cmd == 2'b00);
    assign rd_en    = io_space && (mem_cmd == 2'b01);
    assign io_sel   = rd_en;
    assign led      = led_reg;

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            case (offset)
                OFF_SWITCH: rd_data = DATA_W'(sw_stable);
                OFF_LED:    rd_data = DATA_W'(led_reg);
                OFF_HEXVAL: rd_data = DATA_W'(hex_reg);
                OFF_CTRL:   rd_data = DATA_W'(ctrl_reg);
                OFF_STATUS: rd_data = DATA_W'(changed);
                default:    rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_reg  <= '0;
            hex_reg  <= '0;
            ctrl_reg <= 3'b100;
        end else if (wr_en) begin
            case (offset)
                OFF_LED:    led_reg  <= wr_data[LED_W-1:0];
                OFF_HEXVAL: hex_reg  <= wr_data[HEX_W-1:0];
                OFF_CTRL:   ctrl_reg <= wr_data[2:0];
                default:    ;
            endcase
        end
    end

    // The counter holds at DB_MAX so a stable input keeps re-accepting the same candidate.
    assign sw_diff     = (sw_sync2 != sw_cand);
    assign sw_accept   = !sw_diff && (db_cnt == DB_MAX);
    assign changed_set = sw_accept && (sw_cand != sw_stable);
    assign status_clr  = rd_en && (offset == OFF_STATUS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_sync1  <= '0;
            sw_sync2  <= '0;
            sw_cand   <= '0;
            sw_stable <= '0;
            db_cnt    <= '0;
            changed   <= 1'b0;
        end else begin
            sw_sync1 <= sw;
            sw_sync2 <= sw_sync1;
            if (sw_diff) begin
                sw_cand <= sw_sync2;
                db_cnt  <= '0;
            end else if (sw_accept) begin
                sw_stable <= sw_cand;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (changed_set) begin
                changed <= 1'b1;
            end else if (status_clr) begin
                changed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0011000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Walk from the most significant digit down so hi_zero means "this and all higher nibbles are 0".
    always_comb begin
        logic       hi_zero;
        logic [3:0] nib;
        logic       blank;
        segs    = '1;
        hi_zero = 1'b1;
        nib     = '0;
        blank   = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib     = hex_reg[4*k +: 4];
            hi_zero = hi_zero && (nib == 4'h0);
            blank   = !ctrl_reg[2]
                   || (ctrl_reg[0] && blink_cnt[BLINK_W-1])
                   || (ctrl_reg[1] && (k > 0) && hi_zero);
            segs[7*k +: 7] = blank ? 7'b1111111 : hex7(nib);
        end
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb/tb_mmio_io_ctrl.sv - self-checking bench for mmio_io_ctrl
module tb_mmio_io_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mem_cmd = 2'b10;
    logic [8:0]  mem_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic        io_sel;
    logic [9:0]  sw = '0;
    logic [8:0]  led;
    logic [27:0] segs;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb_q[$];
    logic [3:0]  bc;

    localparam logic [27:0] ALL_ZERO  = {4{7'b1000000}};
    localparam logic [27:0] ALL_BLANK = {4{7'b1111111}};
    localparam logic [27:0] PAT_1A3F  = {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110};

    typedef struct {
        logic [15:0] ctrl;
        logic [15:0] hex;
        logic [27:0] exp_segs;
    } vec_t;
    vec_t vecs[8];

    mmio_io_ctrl #(
        .DATA_W(16), .ADDR_W(9), .DIGITS(4), .SW_W(10), .LED_W(9),
        .DEBOUNCE(4), .BLINK_W(4)
    ) dut (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .wr_data(wr_data), .rd_data(rd_data), .io_sel(io_sel), .sw(sw),
        .led(led), .segs(segs)
    );

    always #5 clk = ~clk;

    // Reference blink phase, independent of the DUT's internals.
    always @(posedge clk or posedge reset) begin
        if (reset) bc <= '0;
        else       bc <= bc + 4'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        mem_cmd  = 2'b00;
        mem_addr = a;
        wr_data  = d;
        cyc();
        mem_cmd  = 2'b10;
    endtask

    task automatic rd(input string name, input logic [8:0] a, input logic [15:0] exp);
        logic [31:0] e;
        mem_cmd  = 2'b01;
        mem_addr = a;
        sb_q.push_back({16'h0, exp});
        @(negedge clk);
        check({name, "_iosel"}, {31'h0, io_sel}, {31'h0, a[8]});
        e = sb_q.pop_front();
        check(name, {16'h0, rd_data}, e);
        cyc();
        mem_cmd = 2'b10;
    endtask

    initial begin
        vecs[0] = '{16'h0004, 16'h1A3F, PAT_1A3F};
        vecs[1] = '{16'h0006, 16'h0050, {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}};
        vecs[2] = '{16'h0006, 16'h0000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
        vecs[3] = '{16'h0000, 16'h1234, ALL_BLANK};
        vecs[4] = '{16'h0006, 16'h0007, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}};
        vecs[5] = '{16'h0006, 16'h0B0C, {7'b1111111, 7'b0000011, 7'b1000000, 7'b1000110}};
        vecs[6] = '{16'hFF0C, 16'h89E6, {7'b0000000, 7'b0011000, 7'b0000110, 7'b0000010}};
        vecs[7] = '{16'h0004, 16'h45D2, {7'b0011001, 7'b0010010, 7'b0100001, 7'b0100100}};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cyc();

        @(negedge clk);
        check("reset_led", {23'h0, led}, 32'h0);
        check("reset_segs", {4'h0, segs}, {4'h0, ALL_ZERO});
        check("idle_rd_data", {16'h0, rd_data}, 32'h0);
        check("idle_io_sel", {31'h0, io_sel}, 32'h0);
        cyc();
        rd("reset_ctrl", 9'h103, 16'h0004);
        rd("unmapped_off7", 9'h107, 16'h0000);
        rd("reset_status", 9'h104, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            wr(9'h103, vecs[i].ctrl);
            wr(9'h102, vecs[i].hex);
            @(negedge clk);
            check($sformatf("vec%0d_segs", i), {4'h0, segs}, {4'h0, vecs[i].exp_segs});
            cyc();
            rd($sformatf("vec%0d_hex", i), 9'h102, vecs[i].hex);
            rd($sformatf("vec%0d_ctrl", i), 9'h103, {13'h0, vecs[i].ctrl[2:0]});
        end

        wr(9'h101, 16'hFFFF);
        rd("led_rd", 9'h101, 16'h01FF);
        check("led_port", {23'h0, led}, 32'h1FF);
        wr(9'h100, 16'hFFFF);
        rd("switch_ro", 9'h100, 16'h0000);
        wr(9'h104, 16'hFFFF);
        rd("status_ro", 9'h104, 16'h0000);
        wr(9'h001, 16'h0000);
        check("ram_space_wr_ignored", {23'h0, led}, 32'h1FF);
        rd("ram_space_rd", 9'h001, 16'h0000);

        sw = 10'h2A5;
        repeat (6) cyc();
        rd("sw_before_lat", 9'h100, 16'h0000);
        rd("sw_at_lat", 9'h100, 16'h02A5);
        rd("status_set", 9'h104, 16'h0001);
        rd("status_cleared", 9'h104, 16'h0000);

        sw = 10'h000;
        repeat (3) cyc();
        sw = 10'h2A5;
        repeat (12) cyc();
        rd("glitch_sw", 9'h100, 16'h02A5);
        rd("glitch_status", 9'h104, 16'h0000);

        sw = 10'h155;
        repeat (6) cyc();
        rd("collide_status_pre", 9'h104, 16'h0000);
        rd("collide_status_kept", 9'h104, 16'h0001);
        rd("collide_status_clr", 9'h104, 16'h0000);
        rd("collide_sw", 9'h100, 16'h0155);

        wr(9'h102, 16'h1A3F);
        wr(9'h103, 16'h0005);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check($sformatf("blink_%0d", i), {4'h0, segs}, {4'h0, (bc[3] ? ALL_BLANK : PAT_1A3F)});
        end
        cyc();

        wr(9'h101, 16'h01FF);
        check("led_pre_reset", {23'h0, led}, 32'h1FF);
        mem_cmd  = 2'b00;
        mem_addr = 9'h101;
        wr_data  = 16'h0123;
        #3 reset = 1'b1;
        #1;
        check("async_reset_led", {23'h0, led}, 32'h0);
        check("async_reset_segs", {4'h0, segs}, {4'h0, ALL_ZERO});
        cyc();
        mem_cmd = 2'b10;
        reset = 1'b0;
        cyc();
        cyc();
        check("post_reset_led", {23'h0, led}, 32'h0);
        rd("post_reset_led_rd", 9'h101, 16'h0000);
        rd("post_reset_ctrl", 9'h103, 16'h0004);
        rd("post_reset_sw", 9'h100, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
